uart_tx_stage: RTL and testbench

//   Serial transmitter downstream of the SoC top's memory-mapped UART registers.

---
 rtl/uart_tx_stage.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stage.sv
// UART transmit stage: edge-triggered byte queue feeding an 8N1 serial line with
// optional even parity; exports busy/done/overflow/level for CPU polling.
module uart_tx_stage #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         uart_data,
    input  logic [7:0]                         uart_ctrl,
    output logic                               tx,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic             req_prev_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             par_en_q;
    logic             par_bit_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic push, pop, full, push_ok, drop;
    logic unused_ctrl;

    assign unused_ctrl = ^uart_ctrl[6:2];

    assign push    = uart_ctrl[0] & ~req_prev_q;
    assign pop     = (state_q == S_IDLE) && (level_q != '0);
    assign full    = (level_q == LVL_FULL);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by level_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= uart_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            req_prev_q <= uart_ctrl[0];
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (uart_ctrl[7]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // tx/done/busy are registered from the current state, so the line lags the FSM
    // by one cycle; busy also holds through the done cycle of the last frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q != S_IDLE) || pop || (level_d != '0);
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        par_bit_q <= ^mem_q[rd_ptr_q];
                        par_en_q  <= uart_ctrl[1];
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (cnt_q == CNT_MAX) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    tx_q <= shift_q[0];
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    tx_q <= par_bit_q;
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage with CLKS_PER_BIT=4: frame shape, parity,
// queueing/overflow, held request and mid-frame reset.
module tb_uart_tx_stage;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_data;
    logic [7:0] uart_ctrl;
    logic       tx, busy, done, overflow;
    logic [2:0] fifo_level;

    int n_chk  = 0;
    int n_fail = 0;

    int n_main;
    int n_b;
    int peak;
    int extra_done;
    int low_cnt;

    always #5 clk = ~clk;

    uart_tx_stage #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_data  (uart_data),
        .uart_ctrl  (uart_ctrl),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until tx is seen low (bounded); n is the number of cycles taken.
    task automatic wait_fall(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (tx !== 1'b0 && n < 200);
        chk({tag, "_fall"}, {31'd0, tx}, 32'd0);
    endtask

    // Called on the first sample with tx low; walks the whole frame plus one cycle.
    task automatic check_frame(input string tag, input logic [7:0] b, input bit par,
                               input bit busy_after);
        logic [10:0] bits;
        int nb;
        nb   = par ? 11 : 10;
        bits = par ? {1'b1, ^b, b, 1'b0} : {1'b0, 1'b1, b, 1'b0};
        for (int off = 0; off <= nb * CPB; off++) begin
            if (off > 0) tick();
            if (off < nb * CPB && (off % CPB) == 1)
                chk({tag, "_bit"}, {31'd0, tx}, {31'd0, bits[off / CPB]});
            chk({tag, "_done"}, {31'd0, done}, (off == nb * CPB - 1) ? 32'd1 : 32'd0);
            if (off == 0)
                chk({tag, "_busy_in"}, {31'd0, busy}, 32'd1);
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, {31'd0, busy_after});
        chk({tag, "_tx_end"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        uart_data = 8'h00;
        uart_ctrl = 8'h00;

        // Reset held for five cycles
        repeat (5) tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        rst = 1'b0;
        tick();

        // Single 0x55 frame, no parity, with push/pop latency
        uart_data = 8'h55;
        uart_ctrl = 8'h01;
        tick();
        chk("t2_busy_rise", {31'd0, busy}, 32'd1);
        chk("t2_level_push", {29'd0, fifo_level}, 32'd1);
        chk("t2_tx_idle", {31'd0, tx}, 32'd1);
        uart_ctrl = 8'h00;
        tick();
        chk("t2_level_pop", {29'd0, fifo_level}, 32'd0);
        chk("t2_tx_pop", {31'd0, tx}, 32'd1);
        wait_fall("t2", n_main);
        chk("t2_latency", n_main, 32'd1);
        check_frame("t2", 8'h55, 1'b0, 1'b0);

        // 0x07 with even parity: parity bit is 1; ctrl[1] held through the pop
        uart_data = 8'h07;
        uart_ctrl = 8'h03;
        wait_fall("t3", n_main);
        chk("t3_latency", n_main, 32'd3);
        check_frame("t3", 8'h07, 1'b1, 1'b0);
        uart_ctrl = 8'h00;
        tick();

        // Six requests two cycles apart: 1..5 sent back-to-back, 6 dropped
        peak = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    uart_data = 8'(i);
                    uart_ctrl = 8'h01;
                    tick();
                    if (int'(fifo_level) > peak) peak = int'(fifo_level);
                    if (i == 5) begin
                        chk("t4_level5", {29'd0, fifo_level}, 32'd4);
                        chk("t4_ovf5", {31'd0, overflow}, 32'd0);
                    end
                    if (i == 6) begin
                        chk("t4_level6", {29'd0, fifo_level}, 32'd4);
                        chk("t4_ovf6", {31'd0, overflow}, 32'd1);
                    end
                    uart_ctrl = 8'h00;
                    tick();
                    if (int'(fifo_level) > peak) peak = int'(fifo_level);
                end
                chk("t4_peak", peak, 32'd4);
                chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
                uart_ctrl = 8'h80;
                tick();
                chk("t4_ovf_clr", {31'd0, overflow}, 32'd0);
                uart_ctrl = 8'h00;
            end
            begin
                wait_fall("t4_f1", n_b);
                chk("t4_latency", n_b, 32'd3);
                check_frame("t4_f1", 8'h01, 1'b0, 1'b1);
                for (int k = 2; k <= 5; k++) begin
                    wait_fall("t4_fk", n_b);
                    chk("t4_gap", n_b, 32'd1);
                    check_frame("t4_fk", 8'(k), 1'b0, k != 5);
                end
            end
        join
        chk("t4_level_end", {29'd0, fifo_level}, 32'd0);
        chk("t4_busy_end", {31'd0, busy}, 32'd0);

        // Request held high: exactly one frame
        uart_data = 8'hA3;
        uart_ctrl = 8'h01;
        wait_fall("t5", n_main);
        chk("t5_latency", n_main, 32'd3);
        check_frame("t5", 8'hA3, 1'b0, 1'b0);
        extra_done = 0;
        low_cnt    = 0;
        repeat (150) begin
            tick();
            if (done === 1'b1) extra_done++;
            if (tx === 1'b0) low_cnt++;
        end
        chk("t5_extra_done", extra_done, 32'd0);
        chk("t5_extra_tx", low_cnt, 32'd0);
        chk("t5_level", {29'd0, fifo_level}, 32'd0);
        uart_ctrl = 8'h00;
        tick();

        // Reset during DATA bit 3 with two bytes still queued
        for (int i = 0; i < 3; i++) begin
            uart_data = (i == 0) ? 8'h81 : ((i == 1) ? 8'h42 : 8'h24);
            uart_ctrl = 8'h01;
            tick();
            uart_ctrl = 8'h00;
            tick();
        end
        chk("t6_level_q", {29'd0, fifo_level}, 32'd2);
        repeat (14) tick();
        chk("t6_bit3", {31'd0, tx}, 32'd0);
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_tx", {31'd0, tx}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_level", {29'd0, fifo_level}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        extra_done = 0;
        low_cnt    = 0;
        repeat (60) begin
            tick();
            if (done === 1'b1) extra_done++;
            if (tx === 1'b0) low_cnt++;
        end
        chk("t6_no_done", extra_done, 32'd0);
        chk("t6_tx_idle", low_cnt, 32'd0);
        chk("t6_busy_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
